// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and dcache of CPUS cores.
// Dcache beats icache within a core; cores are served round-robin.
module mem_arbiter #(
   parameter int unsigned CPUS = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [CPUS-1:0]       iREN,
   input  logic [CPUS-1:0][31:0] iaddr,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0][31:0] iload,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]       dwait,
   output logic [CPUS-1:0][31:0] dload,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [31:0]           ramaddr,
   output logic [31:0]           ramstore,
   input  logic [31:0]           ramload,
   input  logic [1:0]            ramstate,
   output logic                  ramerr
);

   localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0]  RAM_ACCESS = 2'd2;
   localparam logic [1:0]  RAM_ERROR  = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_gcore, w_gcore_nxt;
   logic [CW-1:0]   r_last, w_last_nxt;
   logic            r_gsel, w_gsel_nxt;
   logic            r_ramerr, w_ramerr_nxt;

   logic [CPUS-1:0] w_dreq;
   logic [CW-1:0]   w_pick;
   logic            w_found;
   logic            w_greq;
   logic            w_done;

   // Core index reached k steps after base, wrapping at CPUS.
   function automatic logic [CW-1:0] f_core(input logic [CW-1:0] base, input int unsigned k);
      f_core = CW'((32'(base) + k) % CPUS);
   endfunction

   assign w_dreq = dREN | dWEN;

   // Round-robin search for the first core with anything pending, starting after last.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned k = 1; k <= CPUS; k++) begin
         if (!w_found && (w_dreq[f_core(r_last, k)] || iREN[f_core(r_last, k)])) begin
            w_found = 1'b1;
            w_pick  = f_core(r_last, k);
         end
      end
   end

   // Granted requester still asking, and whether RAM finishes it this cycle.
   always_comb begin
      w_greq = r_gsel ? w_dreq[r_gcore] : iREN[r_gcore];
      w_done = (r_state == GRANT) && w_greq &&
               ((ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR));
   end

   // State and bookkeeping registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_gcore  <= '0;
         r_gsel   <= 1'b0;
         r_last   <= CW'(CPUS - 1);
         r_ramerr <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gcore  <= w_gcore_nxt;
         r_gsel   <= w_gsel_nxt;
         r_last   <= w_last_nxt;
         r_ramerr <= w_ramerr_nxt;
      end
   end

   // Next-state: pick a winner in IDLE, release the grant on completion or abort.
   always_comb begin
      w_state_nxt  = r_state;
      w_gcore_nxt  = r_gcore;
      w_gsel_nxt   = r_gsel;
      w_last_nxt   = r_last;
      w_ramerr_nxt = r_ramerr;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_gcore_nxt = w_pick;
               w_gsel_nxt  = w_dreq[w_pick];
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!w_greq) begin
               // requester withdrew: give up the slot without advancing round-robin
               w_state_nxt = IDLE;
            end else if (ramstate == RAM_ACCESS) begin
               w_last_nxt  = r_gcore;
               w_state_nxt = IDLE;
            end else if (ramstate == RAM_ERROR) begin
               w_ramerr_nxt = 1'b1;
               w_last_nxt   = r_gcore;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // RAM side: strobes track the granted request combinationally, quiet outside GRANT.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (r_state == GRANT) begin
         if (r_gsel) begin
            ramREN   = dREN[r_gcore] & ~dWEN[r_gcore];
            ramWEN   = dWEN[r_gcore];
            ramaddr  = daddr[r_gcore];
            ramstore = dstore[r_gcore];
         end else begin
            ramREN   = iREN[r_gcore];
            ramaddr  = iaddr[r_gcore];
         end
      end
   end

   // Cache side: stall every request except the one completing this cycle.
   always_comb begin
      for (int unsigned c = 0; c < CPUS; c++) begin
         iwait[c] = iREN[c]   & ~(w_done & ~r_gsel & (r_gcore == CW'(c)));
         dwait[c] = w_dreq[c] & ~(w_done &  r_gsel & (r_gcore == CW'(c)));
         iload[c] = ramload;
         dload[c] = ramload;
      end
   end

   assign ramerr = r_ramerr;

endmodule
